// File: rtl/dna_pkg.sv
// dna_pkg: base nibble codes, loader state encoding and width defaults for the DNA search loader
package dna_pkg;
  localparam logic [3:0] BP_A    = 4'b0001;
  localparam logic [3:0] BP_C    = 4'b0010;
  localparam logic [3:0] BP_G    = 4'b0100;
  localparam logic [3:0] BP_T    = 4'b1000;
  localparam logic [3:0] BP_N    = 4'b1111;
  localparam logic [3:0] BP_NONE = 4'b0000;
  typedef enum logic [5:0] {
    ST_LOAD_BIG   = 6'b000001,
    ST_LOAD_SMALL = 6'b000010,
    ST_PAD        = 6'b000100,
    ST_LAUNCH     = 6'b001000,
    ST_WAIT       = 6'b010000,
    ST_REPORT     = 6'b100000
  } state_e;
  localparam int BIG_SEQ_W   = 32;
  localparam int SMALL_SEQ_W = 8;
  localparam int LOC_W       = 5;
  localparam int TMO_CYCLES  = 256;
  localparam int TMO_W       = 9;
endpackage

// File: rtl/dna_search_loader_if.sv
// dna_search_loader_if: base stream input and search result output of the loader
interface dna_search_loader_if #(parameter int LW = dna_pkg::LOC_W) ();
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          res_valid;
  logic          res_ready;
  logic          res_found;
  logic [LW-1:0] res_location;
  logic          res_error;
  logic          res_timeout;
  modport master (
    output in_data, in_valid, in_last, res_ready,
    input  in_ready, res_valid, res_found, res_location, res_error, res_timeout
  );
  modport slave (
    input  in_data, in_valid, in_last, res_ready,
    output in_ready, res_valid, res_found, res_location, res_error, res_timeout
  );
endinterface

// File: rtl/dna_base_encoder.sv
// dna_base_encoder: case-insensitive ASCII base to one-hot nibble, N is the all-ones wildcard
module dna_base_encoder import dna_pkg::*; (
  input  logic [7:0] ch,
  output logic       valid,
  output logic [3:0] nib
);
  logic [7:0] lc;
  always_comb begin
    lc = ch | 8'h20;
    nib = lc == "a" ? BP_A :
          lc == "c" ? BP_C :
          lc == "g" ? BP_G :
          lc == "t" ? BP_T :
          lc == "n" ? BP_N : BP_NONE;
    valid = nib != BP_NONE;
  end
endmodule

// File: rtl/dna_search_loader.sv
// dna_search_loader: packs reference/query bases for the searcher, launches one search and reports its result
module dna_search_loader import dna_pkg::*; #(
  parameter int BIG_SEQ_SIZE            = BIG_SEQ_W,
  parameter int SMALL_SEQ_SIZE          = SMALL_SEQ_W,
  parameter int OUTER_LOCATION_NUM_SIZE = LOC_W,
  parameter int TIMEOUT_CYCLES          = TMO_CYCLES,
  parameter int TIMEOUT_W               = TMO_W
) (
  input  logic                               CLK,
  input  logic                               RST,
  dna_search_loader_if.slave                 io,
  output logic [BIG_SEQ_SIZE-1:0]            bigSeq,
  output logic [SMALL_SEQ_SIZE-1:0]          smallSeq,
  output logic [OUTER_LOCATION_NUM_SIZE-1:0] startIndex,
  output logic                               START,
  output logic                               SRCH_RSTN,
  input  logic                               DONE,
  input  logic                               found,
  input  logic [OUTER_LOCATION_NUM_SIZE-1:0] location
);
  localparam int BIG_N   = BIG_SEQ_SIZE / 4;
  localparam int SMALL_N = SMALL_SEQ_SIZE / 4;
  localparam int BCW     = $clog2(BIG_N + 1);
  localparam int SCW     = $clog2(SMALL_N + 1);
  state_e state_q, state_d;
  logic [BIG_SEQ_SIZE-1:0] big_q, big_d;
  logic [SMALL_SEQ_SIZE-1:0] small_q, small_d;
  logic [BCW-1:0] big_cnt_q, big_cnt_d;
  logic [SCW-1:0] small_cnt_q, small_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [OUTER_LOCATION_NUM_SIZE-1:0] res_location_q, res_location_d;
  logic err_q, err_d, start_q, start_d, srch_rstn_q, srch_rstn_d, in_ready_q, in_ready_d;
  logic res_valid_q, res_valid_d, res_found_q, res_found_d, res_timeout_q, res_timeout_d;
  logic beat, big_full, small_full, enc_valid;
  logic [3:0] enc_nib;
  dna_base_encoder u_enc (.ch(io.in_data), .valid(enc_valid), .nib(enc_nib));
  always_comb begin
    state_d = state_q;
    big_d = big_q;
    small_d = small_q;
    big_cnt_d = big_cnt_q;
    small_cnt_d = small_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    err_d = err_q;
    srch_rstn_d = srch_rstn_q;
    res_valid_d = res_valid_q;
    res_found_d = res_found_q;
    res_location_d = res_location_q;
    res_timeout_d = res_timeout_q;
    beat = io.in_valid && in_ready_q;
    big_full = big_cnt_q == BCW'(BIG_N);
    small_full = small_cnt_q == SCW'(SMALL_N);
    unique case (state_q)
      ST_LOAD_BIG: if (beat) begin
        err_d = err_q | ~enc_valid | big_full;
        big_d = big_full ? big_q : {big_q[BIG_SEQ_SIZE-5:0], enc_nib};
        big_cnt_d = big_full ? big_cnt_q : big_cnt_q + 1'b1;
        if (io.in_last) state_d = big_cnt_d == BCW'(BIG_N) ? ST_LOAD_SMALL : ST_PAD;
      end
      ST_LOAD_SMALL: if (beat) begin
        err_d = err_q | ~enc_valid | small_full;
        small_d = small_full ? small_q : {small_q[SMALL_SEQ_SIZE-5:0], enc_nib};
        small_cnt_d = small_full ? small_cnt_q : small_cnt_q + 1'b1;
        if (io.in_last) state_d = small_cnt_d == SCW'(SMALL_N) ? ST_LAUNCH : ST_PAD;
      end
      // Padding always completes the reference word first, so a full big word means we pad the query
      ST_PAD: if (!big_full) begin
        big_d = {big_q[BIG_SEQ_SIZE-5:0], BP_NONE};
        big_cnt_d = big_cnt_q + 1'b1;
        if (big_cnt_d == BCW'(BIG_N)) state_d = ST_LOAD_SMALL;
      end else begin
        small_d = {small_q[SMALL_SEQ_SIZE-5:0], BP_NONE};
        small_cnt_d = small_cnt_q + 1'b1;
        if (small_cnt_d == SCW'(SMALL_N)) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        tmo_cnt_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (DONE || tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          res_valid_d = 1'b1;
          res_found_d = DONE & found;
          res_location_d = DONE ? location : res_location_q;
          res_timeout_d = ~DONE;
          srch_rstn_d = 1'b0;
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        srch_rstn_d = 1'b1;
        if (io.res_ready) begin
          res_valid_d = 1'b0;
          big_cnt_d = '0;
          small_cnt_d = '0;
          tmo_cnt_d = '0;
          err_d = 1'b0;
          res_timeout_d = 1'b0;
          state_d = ST_LOAD_BIG;
        end
      end
      default: state_d = ST_LOAD_BIG;
    endcase
    start_d = state_d == ST_LAUNCH;
    in_ready_d = state_d == ST_LOAD_BIG || state_d == ST_LOAD_SMALL;
    if (start_d) srch_rstn_d = 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_LOAD_BIG;
      big_q <= '0;
      small_q <= '0;
      big_cnt_q <= '0;
      small_cnt_q <= '0;
      tmo_cnt_q <= '0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      srch_rstn_q <= 1'b0;
      in_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_location_q <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      big_q <= big_d;
      small_q <= small_d;
      big_cnt_q <= big_cnt_d;
      small_cnt_q <= small_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_q <= err_d;
      start_q <= start_d;
      srch_rstn_q <= srch_rstn_d;
      in_ready_q <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_found_q <= res_found_d;
      res_location_q <= res_location_d;
      res_timeout_q <= res_timeout_d;
    end
  end
  // The searcher is held in reset combinationally so it resets in the same cycle as the loader
  assign SRCH_RSTN = srch_rstn_q & ~RST;
  assign START = start_q;
  assign bigSeq = big_q;
  assign smallSeq = small_q;
  assign startIndex = OUTER_LOCATION_NUM_SIZE'(BIG_SEQ_SIZE - 1);
  assign io.in_ready = in_ready_q;
  assign io.res_valid = res_valid_q;
  assign io.res_found = res_found_q;
  assign io.res_location = res_location_q;
  assign io.res_error = err_q;
  assign io.res_timeout = res_timeout_q;
endmodule

// File: tb/tb_dna_search_loader.sv
// tb_dna_search_loader: randomized and directed checks of the loader against a string-level reference model
module tb_dna_search_loader;
  typedef byte bq_t[$];
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] bigSeq;
  logic [7:0] smallSeq;
  logic [4:0] startIndex, location;
  logic START, SRCH_RSTN, DONE, found;
  int checks = 0, fails = 0, cyc = 0;
  int start_cyc = 0, start_cnt = 0, rstn_low = 0;
  bit stub_en = 1'b0;
  int stub_delay = 3;
  logic stub_found = 1'b0;
  logic [4:0] stub_loc = '0;
  dna_search_loader_if io ();
  dna_search_loader dut (
    .CLK(CLK), .RST(RST), .io(io),
    .bigSeq(bigSeq), .smallSeq(smallSeq), .startIndex(startIndex),
    .START(START), .SRCH_RSTN(SRCH_RSTN), .DONE(DONE), .found(found), .location(location)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (START) begin start_cnt++; start_cyc = cyc; rstn_low = 0; end
    if (!SRCH_RSTN) rstn_low++;
  end
  // Stub searcher: answers stub_delay cycles after START, drives junk result bits otherwise
  initial begin
    DONE = 1'b0; found = 1'b0; location = '0;
    forever begin
      @(posedge CLK); #1;
      if (!DONE) begin found = 1'($urandom); location = 5'($urandom); end
      if (START && stub_en) begin
        repeat (stub_delay) @(posedge CLK);
        #1; DONE = 1'b1; found = stub_found; location = stub_loc;
        @(posedge CLK); #1; DONE = 1'b0;
      end
    end
  end
  function automatic logic [3:0] enc(byte c);
    case (c)
      "A", "a": return 4'h1;
      "C", "c": return 4'h2;
      "G", "g": return 4'h4;
      "T", "t": return 4'h8;
      "N", "n": return 4'hF;
      default:  return 4'h0;
    endcase
  endfunction
  function automatic logic [31:0] pack(bq_t s, int n);
    logic [31:0] w = '0;
    for (int i = 0; i < s.size() && i < n; i++) w = w | (32'(enc(s[i])) << (4 * (n - 1 - i)));
    return w;
  endfunction
  function automatic bit bad(bq_t s, int n);
    if (s.size() > n) return 1'b1;
    foreach (s[i]) if (enc(s[i]) == 4'h0) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bq_t to_q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction
  function automatic bq_t rand_seq(int len);
    bq_t q;
    string alpha = "ACGTNacgtn";
    string badc = "XZ#e";
    for (int i = 0; i < len; i++)
      q.push_back($urandom_range(0, 11) == 0 ? badc[$urandom_range(0, 3)] : alpha[$urandom_range(0, 9)]);
    return q;
  endfunction
  task automatic send(input byte ch, input bit last);
    int n = 0;
    io.in_data = ch; io.in_valid = 1'b1; io.in_last = last;
    while (!io.in_ready && n < 300) begin @(posedge CLK); #1; n++; end
    if (!io.in_ready) begin checks++; fails++; $display("FAIL send: in_ready=%b stuck, required 1", io.in_ready); end
    @(posedge CLK); #1;
    io.in_valid = 1'b0; io.in_last = 1'b0;
  endtask
  task automatic load(input bq_t s);
    foreach (s[i]) send(s[i], i == s.size() - 1);
  endtask
  task automatic wait_res(input int lim);
    int n = 0;
    while (!io.res_valid && n < lim) begin @(posedge CLK); #1; n++; end
  endtask
  task automatic consume();
    io.res_ready = 1'b1;
    @(posedge CLK); #1;
    io.res_ready = 1'b0;
  endtask
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if ({bigSeq, smallSeq} !== 40'h0) begin fails++; $display("FAIL reset_seq: got %h/%h required 0/0", bigSeq, smallSeq); end
    checks++; if ({START, SRCH_RSTN, io.in_ready} !== 3'b000) begin fails++; $display("FAIL reset_ctl: START/SRCH_RSTN/in_ready=%b required 000", {START, SRCH_RSTN, io.in_ready}); end
    checks++; if ({io.res_valid, io.res_found, io.res_location, io.res_error, io.res_timeout} !== 9'h0) begin fails++; $display("FAIL reset_res: got %b required 0", {io.res_valid, io.res_found, io.res_location, io.res_error, io.res_timeout}); end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: in_ready=%b required 1", io.in_ready); end
    checks++; if (SRCH_RSTN !== 1'b0) begin fails++; $display("FAIL reset_rstn: SRCH_RSTN=%b required 0 before launch", SRCH_RSTN); end
  endtask
  task automatic test_basic();
    int sc;
    stub_en = 1'b1; stub_delay = 3; stub_found = 1'b1; stub_loc = 5'd7;
    sc = start_cnt;
    load(to_q("ACGTACGT"));
    load(to_q("GT"));
    checks++; if (START !== 1'b1) begin fails++; $display("FAIL basic_start: START=%b required 1 after last query beat", START); end
    checks++; if (bigSeq !== 32'h12481248) begin fails++; $display("FAIL basic_big: got %h required 12481248", bigSeq); end
    checks++; if (smallSeq !== 8'h48) begin fails++; $display("FAIL basic_small: got %h required 48", smallSeq); end
    checks++; if (startIndex !== 5'd31) begin fails++; $display("FAIL basic_idx: got %0d required 31", startIndex); end
    @(posedge CLK); #1;
    checks++; if (START !== 1'b0) begin fails++; $display("FAIL basic_start_len: START=%b required 0", START); end
    wait_res(100);
    checks++; if ({io.res_valid, io.res_found, io.res_location, io.res_error, io.res_timeout} !== {1'b1, 1'b1, 5'd7, 1'b0, 1'b0}) begin fails++; $display("FAIL basic_res: got %b required 1_1_00111_0_0", {io.res_valid, io.res_found, io.res_location, io.res_error, io.res_timeout}); end
    checks++; if (start_cnt - sc !== 1) begin fails++; $display("FAIL basic_start_cnt: got %0d required 1", start_cnt - sc); end
    consume();
  endtask
  task automatic test_done_timing();
    stub_en = 1'b1; stub_delay = 3; stub_found = 1'b1; stub_loc = 5'd19;
    load(to_q("TTGCANCA"));
    load(to_q("CA"));
    wait_res(100);
    checks++; if (io.res_valid !== 1'b1) begin fails++; $display("FAIL done_valid: res_valid=%b required 1", io.res_valid); end
    checks++; if (cyc - start_cyc !== 4) begin fails++; $display("FAIL done_latency: START to res_valid=%0d cycles required 4", cyc - start_cyc); end
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      checks++; if ({io.res_valid, io.res_found, io.res_location} !== {1'b1, 1'b1, 5'd19}) begin fails++; $display("FAIL done_hold%0d: got %b required 1_1_10011", k, {io.res_valid, io.res_found, io.res_location}); end
    end
    checks++; if (rstn_low !== 1) begin fails++; $display("FAIL done_rstn_pulse: low for %0d cycles required 1", rstn_low); end
    checks++; if (SRCH_RSTN !== 1'b1) begin fails++; $display("FAIL done_rstn: SRCH_RSTN=%b required 1", SRCH_RSTN); end
    consume();
    checks++; if ({io.res_valid, io.in_ready} !== 2'b01) begin fails++; $display("FAIL done_consume: valid/ready=%b required 01", {io.res_valid, io.in_ready}); end
  endtask
  task automatic test_pad();
    stub_en = 1'b1; stub_delay = 2; stub_found = 1'b0; stub_loc = 5'd3;
    load(to_q("acg"));
    for (int i = 0; i < 5; i++) begin
      checks++; if (io.in_ready !== 1'b0) begin fails++; $display("FAIL pad_ready%0d: in_ready=%b required 0", i, io.in_ready); end
      @(posedge CLK); #1;
    end
    checks++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL pad_done: in_ready=%b required 1", io.in_ready); end
    checks++; if (bigSeq !== 32'h12400000) begin fails++; $display("FAIL pad_big: got %h required 12400000", bigSeq); end
    load(to_q("T"));
    @(posedge CLK); #1;
    checks++; if ({START, smallSeq} !== {1'b1, 8'h80}) begin fails++; $display("FAIL pad_small: START/small=%b/%h required 1/80", START, smallSeq); end
    wait_res(100);
    checks++; if ({io.res_valid, io.res_found, io.res_error} !== 3'b100) begin fails++; $display("FAIL pad_res: got %b required 100", {io.res_valid, io.res_found, io.res_error}); end
    consume();
  endtask
  task automatic test_error();
    stub_en = 1'b1; stub_delay = 4; stub_found = 1'b1; stub_loc = 5'd2;
    load(to_q("ACGXACGT"));
    load(to_q("GT"));
    checks++; if (bigSeq !== 32'h12401248) begin fails++; $display("FAIL err_big: got %h required 12401248", bigSeq); end
    wait_res(100);
    checks++; if (io.res_error !== 1'b1) begin fails++; $display("FAIL err_flag: res_error=%b required 1", io.res_error); end
    consume();
    checks++; if (io.res_error !== 1'b0) begin fails++; $display("FAIL err_clear: res_error=%b required 0", io.res_error); end
    load(to_q("ACGTACGTA"));
    load(to_q("A"));
    @(posedge CLK); #1;
    checks++; if ({bigSeq, smallSeq} !== {32'h12481248, 8'h10}) begin fails++; $display("FAIL ovf_seq: got %h/%h required 12481248/10", bigSeq, smallSeq); end
    wait_res(100);
    checks++; if (io.res_error !== 1'b1) begin fails++; $display("FAIL ovf_flag: res_error=%b required 1", io.res_error); end
    consume();
  endtask
  task automatic test_timeout();
    stub_en = 1'b0;
    load(to_q("NNNN"));
    load(to_q("AC"));
    wait_res(400);
    checks++; if (io.res_valid !== 1'b1) begin fails++; $display("FAIL tmo_valid: res_valid=%b required 1", io.res_valid); end
    checks++; if (cyc - start_cyc !== 257) begin fails++; $display("FAIL tmo_latency: START to res_valid=%0d cycles required 257", cyc - start_cyc); end
    checks++; if ({io.res_timeout, io.res_found} !== 2'b10) begin fails++; $display("FAIL tmo_flags: timeout/found=%b required 10", {io.res_timeout, io.res_found}); end
    consume();
    checks++; if (io.res_timeout !== 1'b0) begin fails++; $display("FAIL tmo_clear: res_timeout=%b required 0", io.res_timeout); end
  endtask
  task automatic test_reset_in_wait();
    stub_en = 1'b0;
    load(to_q("GATTACA"));
    load(to_q("T"));
    repeat (5) @(posedge CLK);
    #1;
    checks++; if (SRCH_RSTN !== 1'b1) begin fails++; $display("FAIL rw_armed: SRCH_RSTN=%b required 1", SRCH_RSTN); end
    RST = 1'b1;
    #1;
    checks++; if (SRCH_RSTN !== 1'b0) begin fails++; $display("FAIL rw_rstn_now: SRCH_RSTN=%b required 0 while RST", SRCH_RSTN); end
    @(posedge CLK); #1;
    checks++; if ({START, io.res_valid, io.in_ready, bigSeq, smallSeq} !== 43'h0) begin fails++; $display("FAIL rw_state: START/valid/ready=%b big=%h small=%h required all 0", {START, io.res_valid, io.in_ready}, bigSeq, smallSeq); end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if ({io.in_ready, SRCH_RSTN} !== 2'b10) begin fails++; $display("FAIL rw_recover: ready/rstn=%b required 10", {io.in_ready, SRCH_RSTN}); end
  endtask
  task automatic test_random();
    bq_t b, s;
    int sc, stall;
    stub_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      b = rand_seq($urandom_range(1, 10));
      s = rand_seq($urandom_range(1, 3));
      stub_delay = $urandom_range(1, 12);
      stub_found = 1'($urandom);
      stub_loc = 5'($urandom);
      stall = $urandom_range(0, 3);
      sc = start_cnt;
      load(b);
      load(s);
      while (!START && !io.res_valid && io.in_ready !== 1'b1) begin @(posedge CLK); #1; end
      checks++; if ({bigSeq, smallSeq} !== {pack(b, 8), 8'(pack(s, 2))}) begin fails++; $display("FAIL rnd%0d_seq: got %h/%h required %h/%h", it, bigSeq, smallSeq, pack(b, 8), 8'(pack(s, 2))); end
      wait_res(100);
      repeat (stall) begin @(posedge CLK); #1; end
      checks++; if ({io.res_valid, io.res_found, io.res_location, io.res_timeout} !== {1'b1, stub_found, stub_loc, 1'b0}) begin fails++; $display("FAIL rnd%0d_res: got %b required %b", it, {io.res_valid, io.res_found, io.res_location, io.res_timeout}, {1'b1, stub_found, stub_loc, 1'b0}); end
      checks++; if (io.res_error !== (bad(b, 8) | bad(s, 2))) begin fails++; $display("FAIL rnd%0d_err: res_error=%b required %b", it, io.res_error, bad(b, 8) | bad(s, 2)); end
      checks++; if (start_cnt - sc !== 1) begin fails++; $display("FAIL rnd%0d_start: START pulses=%0d required 1", it, start_cnt - sc); end
      consume();
    end
  endtask
  initial begin
    io.in_data = 8'h0; io.in_valid = 1'b0; io.in_last = 1'b0; io.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_done_timing();
    test_pad();
    test_error();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dna_search_loader.md
Name: dna_search_loader

Overview:
Upstream feeder and result collector for the DNA searcher stage. Accepts a byte stream of ASCII bases, one-hot encodes each base into a 4-bit nibble, and packs the reference sequence and query sequence into the searcher's `bigSeq` and `smallSeq` words. It then launches one search, waits for `DONE`, and presents the result on a valid/ready port. After capturing each result it re-arms the searcher with an active-low reset pulse.

Parameters:
BIG_SEQ_SIZE, 32, width of packed reference word (BIG_SEQ_SIZE/4 bases)
SMALL_SEQ_SIZE, 8, width of packed query word (SMALL_SEQ_SIZE/4 bases)
OUTER_LOCATION_NUM_SIZE, 5, width of startIndex/location
TIMEOUT_CYCLES, 256, max cycles waiting for DONE before abort
TIMEOUT_W, 9, width of timeout counter

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
in_data  in  8  ASCII base character
in_valid  in  1  in_data valid
in_last  in  1  final character of current sequence
in_ready  out  1  loader accepts a beat
bigSeq  out  BIG_SEQ_SIZE  packed reference to searcher
smallSeq  out  SMALL_SEQ_SIZE  packed query to searcher
startIndex  out  OUTER_LOCATION_NUM_SIZE  search start position, constant BIG_SEQ_SIZE-1
START  out  1  one-cycle launch pulse to searcher
SRCH_RSTN  out  1  active-low reset to searcher
DONE  in  1  searcher completion
found  in  1  searcher match flag
location  in  OUTER_LOCATION_NUM_SIZE  searcher match position
res_valid  out  1  result available
res_ready  in  1  result consumed
res_found  out  1  captured found
res_location  out  OUTER_LOCATION_NUM_SIZE  captured location
res_error  out  1  bad character or overflow occurred during load
res_timeout  out  1  DONE not seen within TIMEOUT_CYCLES

Behaviour:
- Reset values:
  - state=LOAD_BIG, bigSeq=0, smallSeq=0, START=0, SRCH_RSTN=0.
  - res_valid=0, res_found=0, res_location=0, res_error=0, res_timeout=0.
  - Base counters=0, timeout counter=0.
  - in_ready=1 one cycle after reset releases.
- Encoding (case-insensitive):
  - A→0001, C→0010, G→0100, T→1000, N→1111 (wildcard).
  - Any other byte → 0000 and sets the sticky error flag.
- Packing:
  - Each accepted beat (in_valid&&in_ready) shifts the target word left by 4 and inserts the nibble at bits [3:0].
  - The first base therefore ends in the MS nibble once the sequence is full.
  - On in_last with fewer than capacity bases, the word is left-justified by shifting in zero nibbles, one per cycle, with in_ready=0 during padding.
  - Beats beyond capacity are accepted, dropped, and set the sticky error flag.
- States:
  - LOAD_BIG: in_ready=1; load bigSeq. Beat with in_last → LOAD_SMALL (or pad first).
  - LOAD_SMALL: same for smallSeq; in_last → LAUNCH.
  - LAUNCH: in_ready=0, SRCH_RSTN=1, START=1 for exactly one cycle → WAIT. bigSeq, smallSeq and startIndex stay stable from LAUNCH through REPORT.
  - WAIT:
    - START=0; timeout counter increments each cycle.
    - DONE=1 → capture found and location into res_*, drive SRCH_RSTN=0 for one cycle, go to REPORT.
    - Counter reaches TIMEOUT_CYCLES-1 with DONE=0 → res_timeout=1, res_found=0, SRCH_RSTN=0 for one cycle, go to REPORT.
    - DONE and timeout in the same cycle: DONE wins.
  - REPORT:
    - res_valid=1, SRCH_RSTN=1 from the second cycle onward.
    - On res_valid&&res_ready: res_valid=0; clear counters, error and timeout flags; bigSeq/smallSeq retained; go to LOAD_BIG.
- Latency: last query beat to START is 1 cycle (plus any padding cycles). DONE to res_valid is 1 cycle.
- in_valid while in_ready=0 is ignored; the beat is not consumed.
- RST mid-operation: immediate return to reset values. SRCH_RSTN is held low while RST is high, so the searcher resets with the loader.
- A zero-length sequence (in_last on an empty word is impossible because the in_last beat carries one base) is not a case; minimum sequence length is 1 base.

Decomposition:
- Shared package dna_pkg:
  - Base nibble constants: BP_A, BP_C, BP_G, BP_T, BP_N, BP_NONE.
  - Loader state encodings: one-hot, 6 bits.
  - Shared width defaults.
- One sub-module: dna_base_encoder, combinational, 8-bit ASCII → {valid, 4-bit nibble}, instantiated once.

Test Plan:
- Stream "ACGTACGT" (last on final T), then "GT" → bigSeq=32'h12481248, smallSeq=8'h48, startIndex=31, START high exactly one cycle, the cycle after the "T" of the query is accepted.
- Stream "acg" + last, then "T" + last → bigSeq=32'h12400000 after 5 padding cycles (in_ready=0 during padding), smallSeq=8'h80.
- Stub searcher asserts DONE=1, found=1, location=5'd19 three cycles after START → res_valid next cycle with res_found=1, res_location=19; SRCH_RSTN low exactly one cycle; res_ready held 0 for 4 cycles keeps res_valid=1 and outputs stable.
- Reference "ACGXACGT" → bigSeq nibble 4 = 0000; res_error=1 in the result. A 9-base reference also gives res_error=1 and bigSeq holds only the first 8 bases.
- Stub never asserts DONE → after TIMEOUT_CYCLES cycles in WAIT: res_valid=1, res_timeout=1, res_found=0.
- Assert RST in WAIT → next cycle: state LOAD_BIG, START=0, SRCH_RSTN=0, res_valid=0, bigSeq=0.
